// File: rtl/vec_arb_pkg.sv
// Shared types and defaults for the vector-read arbiter.
// The FSM has two states: arbitrate among all units, or serve only the locked owner.
package vec_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int unsigned BUF_ID_W_DEFAULT = 5;

endpackage

// File: rtl/vec_read_arbiter_if.sv
// Request, response and buffer-controller signals of the vector-read arbiter.
// The slave modport is the arbiter's view; master is the units plus buffer controller.
interface vec_read_arbiter_if
  import vec_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TILE_ELEMS = 32,
  parameter int unsigned BUF_ID_W   = BUF_ID_W_DEFAULT
) ();

  // Execution-unit side
  logic [NUM_REQ-1:0]                    req_enable;
  logic [NUM_REQ*BUF_ID_W-1:0]           req_buffer_id;
  logic [NUM_REQ-1:0]                    req_lock;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ-1:0]                    rsp_valid;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] rsp_tile;

  // Buffer-controller side
  logic                                  bc_read_enable;
  logic [BUF_ID_W-1:0]                   bc_read_buffer_id;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] bc_read_tile;
  logic                                  bc_read_valid;

  modport slave (
    input  req_enable,
    input  req_buffer_id,
    input  req_lock,
    input  bc_read_tile,
    input  bc_read_valid,
    output req_ready,
    output rsp_valid,
    output rsp_tile,
    output bc_read_enable,
    output bc_read_buffer_id
  );

  modport master (
    output req_enable,
    output req_buffer_id,
    output req_lock,
    output bc_read_tile,
    output bc_read_valid,
    input  req_ready,
    input  rsp_valid,
    input  rsp_tile,
    input  bc_read_enable,
    input  bc_read_buffer_id
  );

endinterface

// File: rtl/owner_fifo.sv
// In-order FIFO of requester indices, one entry per in-flight read.
// Push is honoured when full only if a pop happens in the same cycle.
module owner_fifo
  import vec_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCnt);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/vec_read_arbiter.sv
// Round-robin arbiter sharing one buffer-controller read port among NUM_REQ units,
// with optional burst lock and in-order routing of returned tiles to their issuer.
module vec_read_arbiter
  import vec_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned TILE_ELEMS      = 32,
  parameter int unsigned BUF_ID_W        = BUF_ID_W_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  vec_read_arbiter_if.slave                  bus,
  output logic [$clog2(NUM_REQ)-1:0]         owner_o,
  output logic                               locked_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_spurious_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                bc_en_q, bc_en_d;
  logic [BUF_ID_W-1:0] bc_id_q, bc_id_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  tile_t               rsp_tile_q, rsp_tile_d;
  logic                err_q, err_d;

  logic [IdxW-1:0]     cand;
  logic [IdxW-1:0]     win_idx;
  logic                win_found;
  logic [IdxW-1:0]     acc_idx;
  logic [NUM_REQ-1:0]  req_ready;
  logic                accept;
  logic                can_push;
  logic                pop;
  logic                spurious;

  logic [IdxW-1:0]     fifo_head;
  logic                fifo_empty;
  logic                fifo_full;

  // A return in the same cycle frees a slot, so a full FIFO can still accept.
  assign can_push = !fifo_full || bus.bc_read_valid;
  assign pop      = bus.bc_read_valid && !fifo_empty;
  assign spurious = bus.bc_read_valid && fifo_empty;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_enable[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    req_ready = '0;
    acc_idx   = owner_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = can_push;
          acc_idx            = win_idx;
        end
      end
      ARB_LOCKED: req_ready[owner_q] = can_push;
      default:    req_ready = '0;
    endcase

    accept = |(bus.req_enable & req_ready);

    if (accept) begin
      owner_d  = acc_idx;
      rr_ptr_d = IdxW'((32'(acc_idx) + 1) % NUM_REQ);
    end

    // Dropping the lock still lets a request in the same cycle through.
    unique case (state_q)
      ARB_IDLE: begin
        if (accept && bus.req_lock[acc_idx]) begin
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!bus.req_lock[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bc_en_d     = accept;
    bc_id_d     = bc_id_q;
    rsp_valid_d = '0;
    rsp_tile_d  = rsp_tile_q;
    err_d       = err_q || spurious;
    if (accept) begin
      bc_id_d = bus.req_buffer_id[acc_idx*BUF_ID_W +: BUF_ID_W];
    end
    if (pop) begin
      rsp_valid_d[fifo_head] = 1'b1;
      rsp_tile_d             = bus.bc_read_tile;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      bc_en_q     <= 1'b0;
      bc_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_tile_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      bc_en_q     <= bc_en_d;
      bc_id_q     <= bc_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tile_q  <= rsp_tile_d;
      err_q       <= err_d;
    end
  end

  owner_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (IdxW)
  ) u_owner_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (accept),
    .data_i  (acc_idx),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (outstanding_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.req_ready         = req_ready;
  assign bus.bc_read_enable    = bc_en_q;
  assign bus.bc_read_buffer_id = bc_id_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_tile          = rsp_tile_q;

  assign owner_o        = owner_q;
  assign locked_o       = (state_q == ARB_LOCKED);
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_vec_read_arbiter.sv
// Directed bench for vec_read_arbiter: stimulus issues requests, a tracker builds the
// expected return stream and a monitor compares every rsp_valid against it.
module tb_vec_read_arbiter;

  typedef logic [31:0][7:0] tile_t;
  typedef struct {
    logic [1:0] idx;
    tile_t      tile;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_read_arbiter_if #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .TILE_ELEMS (32),
    .BUF_ID_W   (5)
  ) bus ();

  logic [1:0] owner;
  logic       locked;
  logic [2:0] outstanding;
  logic       err_spurious;

  vec_read_arbiter #(
    .NUM_REQ         (4),
    .DATA_WIDTH      (8),
    .TILE_ELEMS      (32),
    .BUF_ID_W        (5),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .owner_o        (owner),
    .locked_o       (locked),
    .outstanding_o  (outstanding),
    .err_spurious_o (err_spurious)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic       bc_auto = 1'b1;
  logic       auto_valid = 1'b0;
  tile_t      auto_tile = '0;
  logic       man_valid = 1'b0;
  tile_t      man_tile = '0;

  assign bus.bc_read_valid = bc_auto ? auto_valid : man_valid;
  assign bus.bc_read_tile  = bc_auto ? auto_tile : man_tile;

  logic [1:0] issued [$];
  exp_t       exp_q [$];

  function automatic tile_t mk_tile(int s);
    tile_t t;
    for (int e = 0; e < 32; e++) t[e] = 8'(s * 3 + e);
    return t;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Buffer-controller model: fixed latency 1, tile derived from the read id.
  initial begin
    logic       en;
    logic [4:0] id;
    forever begin
      @(negedge clk);
      en = bus.bc_read_enable;
      id = bus.bc_read_buffer_id;
      @(posedge clk);
      #1;
      auto_valid = bc_auto && en && rst;
      if (auto_valid) auto_tile = mk_tile(int'(id));
    end
  end

  // Tracker: issue order in, return data paired with the oldest issuer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      issued.delete();
    end else begin
      if (bus.bc_read_valid && issued.size() > 0) begin
        e.idx  = issued.pop_front();
        e.tile = bus.bc_read_tile;
        exp_q.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.req_enable[i] && bus.req_ready[i]) issued.push_back(2'(i));
      end
    end
  end

  // Monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 256'(bus.rsp_valid), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_valid", 256'(bus.rsp_valid), 256'(4'(1) << e.idx));
        check("sb_rsp_tile", bus.rsp_tile, e.tile);
      end
    end
  end

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    bus.req_enable    = '0;
    bus.req_lock      = '0;
    bus.req_buffer_id = '0;

    // Reset state
    smp();
    smp();
    check("rst_outstanding", 256'(outstanding), 256'(0));
    check("rst_err", 256'(err_spurious), 256'(0));
    check("rst_locked", 256'(locked), 256'(0));
    check("rst_owner", 256'(owner), 256'(0));
    check("rst_bc_en", 256'(bus.bc_read_enable), 256'(0));
    check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    check("rst_rsp_tile", bus.rsp_tile, 256'(0));

    // Round-robin among 0, 1, 3
    cyc();
    rst = 1'b1;
    bus.req_buffer_id = {5'd13, 5'd12, 5'd11, 5'd10};
    bus.req_enable    = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      smp();
      check("rr_grant", 256'(bus.req_enable & bus.req_ready), 256'(4'(1) << rr_exp[k]));
      if (k > 0) check("rr_owner", 256'(owner), 256'(rr_exp[k-1]));
      cyc();
    end
    bus.req_enable = '0;
    smp();
    check("rr_owner_last", 256'(owner), 256'(3));
    repeat (4) cyc();
    smp();
    check("rr_drained", 256'(outstanding), 256'(0));

    // Single requester 2, id 7, latency 1
    cyc();
    bus.req_buffer_id[10 +: 5] = 5'd7;
    bus.req_enable = 4'b0100;
    smp();
    check("single_ready", 256'(bus.req_ready), 256'(4'b0100));
    cyc();
    bus.req_enable = '0;
    smp();
    check("single_bc_en", 256'(bus.bc_read_enable), 256'(1));
    check("single_bc_id", 256'(bus.bc_read_buffer_id), 256'(7));
    check("single_owner", 256'(owner), 256'(2));
    cyc();
    smp();
    check("single_rsp_early", 256'(bus.rsp_valid), 256'(0));
    cyc();
    smp();
    check("single_rsp_valid", 256'(bus.rsp_valid), 256'(4'b0100));
    check("single_rsp_tile", bus.rsp_tile, mk_tile(7));
    cyc();
    smp();
    check("single_rsp_tile_hold", bus.rsp_tile, mk_tile(7));

    // Lock burst by requester 1 while 0 waits
    cyc();
    bus.req_buffer_id[5 +: 5] = 5'd20;
    bus.req_enable = 4'b0010;
    bus.req_lock   = 4'b0010;
    smp();
    check("lock_first_grant", 256'(bus.req_ready), 256'(4'b0010));
    check("lock_first_unlocked", 256'(locked), 256'(0));
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.req_enable = 4'b0011;
      smp();
      check("lock_grant", 256'(bus.req_enable & bus.req_ready), 256'(4'b0010));
      check("lock_locked", 256'(locked), 256'(1));
    end
    cyc();
    bus.req_enable = 4'b0001;
    bus.req_lock   = 4'b0000;
    smp();
    check("lock_release_wait", 256'(bus.req_enable & bus.req_ready), 256'(0));
    check("lock_release_locked", 256'(locked), 256'(1));
    cyc();
    smp();
    check("lock_after_grant0", 256'(bus.req_enable & bus.req_ready), 256'(4'b0001));
    check("lock_after_unlocked", 256'(locked), 256'(0));
    cyc();
    bus.req_enable = '0;
    repeat (4) cyc();
    smp();
    check("lock_drained", 256'(outstanding), 256'(0));

    // Backpressure: 4 accepted, 5th only with a same-cycle return
    cyc();
    bc_auto = 1'b0;
    man_valid = 1'b0;
    bus.req_buffer_id[15 +: 5] = 5'd9;
    bus.req_enable = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("bp_accept", 256'(bus.req_ready), 256'(4'b1000));
      cyc();
    end
    smp();
    check("bp_full_ready", 256'(bus.req_ready), 256'(0));
    check("bp_full_count", 256'(outstanding), 256'(4));
    cyc();
    man_valid = 1'b1;
    man_tile  = mk_tile(40);
    smp();
    check("bp_ready_on_pop", 256'(bus.req_ready), 256'(4'b1000));
    cyc();
    bus.req_enable = '0;
    man_tile = mk_tile(41);
    smp();
    check("bp_push_pop_count", 256'(outstanding), 256'(4));
    check("bp_first_rsp", 256'(bus.rsp_valid), 256'(4'b1000));
    for (int s = 42; s < 45; s++) begin
      cyc();
      man_tile = mk_tile(s);
      smp();
    end
    cyc();
    man_valid = 1'b0;
    smp();
    check("bp_drained", 256'(outstanding), 256'(0));

    // Owners 0, 2, 0 with data A, B, C
    cyc();
    bus.req_enable = 4'b0001;
    smp();
    check("ooo_issue0", 256'(bus.req_ready), 256'(4'b0001));
    cyc();
    bus.req_enable = 4'b0100;
    smp();
    check("ooo_issue2", 256'(bus.req_ready), 256'(4'b0100));
    cyc();
    bus.req_enable = 4'b0001;
    smp();
    check("ooo_issue0b", 256'(bus.req_ready), 256'(4'b0001));
    cyc();
    bus.req_enable = '0;
    man_valid = 1'b1;
    man_tile  = mk_tile(50);
    smp();
    cyc();
    man_tile = mk_tile(51);
    smp();
    check("ooo_rsp_a", 256'(bus.rsp_valid), 256'(4'b0001));
    check("ooo_tile_a", bus.rsp_tile, mk_tile(50));
    cyc();
    man_tile = mk_tile(52);
    smp();
    check("ooo_rsp_b", 256'(bus.rsp_valid), 256'(4'b0100));
    check("ooo_tile_b", bus.rsp_tile, mk_tile(51));
    cyc();
    man_valid = 1'b0;
    smp();
    check("ooo_rsp_c", 256'(bus.rsp_valid), 256'(4'b0001));
    check("ooo_tile_c", bus.rsp_tile, mk_tile(52));

    // Spurious return with empty FIFO
    cyc();
    man_valid = 1'b1;
    man_tile  = mk_tile(60);
    smp();
    check("spur_err_before", 256'(err_spurious), 256'(0));
    cyc();
    man_valid = 1'b0;
    smp();
    check("spur_err_set", 256'(err_spurious), 256'(1));
    check("spur_no_rsp", 256'(bus.rsp_valid), 256'(0));
    cyc();
    smp();
    check("spur_err_sticky", 256'(err_spurious), 256'(1));

    // Reset with two reads in flight; their returns are dropped
    cyc();
    rst = 1'b0;
    smp();
    check("rst2_err_clear", 256'(err_spurious), 256'(0));
    cyc();
    rst = 1'b1;
    bus.req_enable = 4'b0010;
    smp();
    cyc();
    smp();
    cyc();
    bus.req_enable = '0;
    smp();
    check("rst2_inflight", 256'(outstanding), 256'(2));
    cyc();
    rst = 1'b0;
    smp();
    check("rst2_count_clear", 256'(outstanding), 256'(0));
    check("rst2_bc_en_clear", 256'(bus.bc_read_enable), 256'(0));
    cyc();
    rst = 1'b1;
    man_valid = 1'b1;
    man_tile  = mk_tile(70);
    smp();
    cyc();
    man_tile = mk_tile(71);
    smp();
    check("rst2_drop_a", 256'(bus.rsp_valid), 256'(0));
    check("rst2_err_a", 256'(err_spurious), 256'(1));
    cyc();
    man_valid = 1'b0;
    smp();
    check("rst2_drop_b", 256'(bus.rsp_valid), 256'(0));
    check("rst2_err_b", 256'(err_spurious), 256'(1));
    check("rst2_count", 256'(outstanding), 256'(0));

    repeat (3) cyc();
    smp();
    check("end_exp_empty", 256'(exp_q.size()), 256'(0));
    check("end_issued_empty", 256'(issued.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_read_arbiter.md
Name: vec_read_arbiter

Overview:
- Shares the buffer controller's single vector-read port among NUM_REQ execution units (GEMV, ReLU, store, etc.).
- Round-robin grants per tile request. An optional lock keeps ownership across a multi-tile burst.
- Read data returning from the buffer controller goes only to the requester that issued the read, tracked with an in-order owner FIFO.
- Sits between the execution units and the buffer controller.

Parameters:
- NUM_REQ, 4, number of requesting execution units.
- DATA_WIDTH, 8, element width in bits.
- TILE_ELEMS, 32, elements per tile.
- BUF_ID_W, 5, buffer-id width.
- MAX_OUTSTANDING, 4, maximum in-flight reads (owner FIFO depth, power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
- req_enable  in  NUM_REQ  per-requester tile-read request. Held high until accepted.
- req_buffer_id  in  NUM_REQ*BUF_ID_W  buffer id per requester, packed, requester i at [i*BUF_ID_W +: BUF_ID_W].
- req_lock  in  NUM_REQ  requester i asks to keep the grant after this request.
- req_ready  out  NUM_REQ  combinational accept. A request is accepted when req_enable[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot tile-return strobe.
- rsp_tile  out  TILE_ELEMS x DATA_WIDTH signed  returned tile, broadcast to all requesters.
- bc_read_enable  out  1  read strobe to the buffer controller.
- bc_read_buffer_id  out  BUF_ID_W  read buffer id.
- bc_read_tile  in  TILE_ELEMS x DATA_WIDTH signed  tile from the buffer controller.
- bc_read_valid  in  1  tile valid from the buffer controller.
- owner  out  $clog2(NUM_REQ)  current or last granted requester.
- locked  out  1  high while in the LOCKED state.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  owner FIFO occupancy.
- err_spurious  out  1  sticky flag: bc_read_valid arrived while the owner FIFO was empty.

Behaviour:
- Reset (asynchronous, rst low) sets all outputs and state to 0: rr_ptr=0, state=ARB_IDLE, FIFO empty, err_spurious=0, rsp_tile all zero.
- FSM states: ARB_IDLE (arbitrate among all requesters) and ARB_LOCKED (only `owner` is eligible).
- can_push = (outstanding < MAX_OUTSTANDING) || bc_read_valid. A simultaneous pop frees a slot at full.
- ARB_IDLE winner selection:
  - The winner is the first i with req_enable[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner] = can_push. All other req_ready bits are 0.
- On accept by requester i:
  - bc_read_enable <= 1 and bc_read_buffer_id <= req_buffer_id[i] (registered, visible next cycle).
  - Push i into the owner FIFO.
  - owner <= i and rr_ptr <= (i+1) mod NUM_REQ.
  - If req_lock[i] is high, go to ARB_LOCKED.
- ARB_LOCKED:
  - req_ready[owner] = can_push. All other bits are 0.
  - When req_lock[owner] is low in a cycle, return to ARB_IDLE next cycle. A request accepted in that same cycle is still served.
  - Other requesters wait regardless of their req_enable.
- bc_read_enable is 0 in any cycle without an accept. The block issues at most one read per cycle.
- Return path:
  - When bc_read_valid is high: pop the FIFO head h, then next cycle rsp_valid[h]=1 and rsp_tile=bc_read_tile.
  - rsp_tile holds its last value otherwise.
  - Return order equals issue order, so the buffer controller must return reads in order.
- Latency: accept at cycle t gives bc_read_enable at t+1. Data at t+1+L gives rsp_valid at t+2+L.
- Spurious valid: bc_read_valid with an empty FIFO produces no pop and no rsp_valid, and sets err_spurious. err_spurious clears only on reset.
- Simultaneous push and pop in one cycle: occupancy is unchanged and pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: in-flight reads are forgotten. Their later returns set err_spurious.
- No starvation: with continuous requests from all units and no locks, each requester is granted at least once every NUM_REQ accepts.

Decomposition:
- Package vec_arb_pkg holds:
  - typedef arb_state_t {ARB_IDLE, ARB_LOCKED};
  - localparam BUF_ID_W_DEFAULT=5.
- Sub-module owner_fifo: synchronous FIFO of requester indices with push, pop, count, and empty/full flags. Same reset as the parent.

Test Plan:
- Single requester: req_enable[2] held with id 7 and a bc return latency of 1 → req_ready[2] high at t, bc_read_enable high with id 7 at t+1, rsp_valid=4'b0100 at t+3 with the same tile.
- Round-robin: requesters 0, 1 and 3 all requesting continuously, no lock → grants in order 0, 1, 3, 0, 1, 3 and owner follows that order.
- Lock burst: requester 1 holds req_lock for 4 accepts while requester 0 requests → four consecutive grants to 1 with locked=1, then requester 0 is granted within 2 cycles of lock release.
- Backpressure: bc_read_valid held low, 5 requests → exactly 4 accepted (outstanding=4) and req_ready low. Asserting bc_read_valid for one cycle accepts the 5th in that same cycle.
- Out-of-order owners: issues 0, 2, 0 with data A, B, C returned → rsp_valid one-hot 0/A, 2/B, 0/C in sequence.
- Spurious and reset: pulse bc_read_valid with the FIFO empty → err_spurious=1 and no rsp_valid. Reset with 2 reads in flight, then the returns → both dropped and err_spurious=1.
